imem_dmem_arbiter: RTL
======================

// Module: imem_dmem_arbiter
// PURPOSE
//  Shares one single-ported unified memory between the CPU instruction-fetch port and its
//  load/store data port. Per-cycle arbitration with a starvation guard; registered memory
//  command; read responses returned after a fixed latency and routed to the issuing requester.
//  Sits between the cpu core (iaddr / daddr / dwdata / dwe side) and the memory model.
// PARAMETERS
//  AW        32  address width (byte address)
//  DW        32  data width; byte-enable width is DW/8
//  LAT        1  memory read latency in cycles: men registered high at edge E -> mrdata valid after edge E+LAT
//  MAX_WAIT   4  max consecutive lost arbitrations before the loser is forced granted (>=1)
// PORTS
//  clk       in   1      clock; all state changes on posedge
//  reset     in   1      synchronous, active-high reset
//  i_valid   in   1      fetch request pending; held with i_addr until i_ready
//  i_addr    in   AW     fetch address (word-aligned)
//  i_ready   out  1      fetch request accepted this cycle (combinational)
//  i_rvalid  out  1      fetch data valid on i_rdata
//  i_rdata   out  DW     fetch data
//  d_valid   in   1      data request pending; held stable until d_ready
//  d_addr    in   AW     load/store address
//  d_we      in   DW/8   byte write enables; 0 = load
//  d_wdata   in   DW     store data
//  d_ready   out  1      data request accepted this cycle (combinational)
//  d_rvalid  out  1      load data valid on d_rdata (never pulsed for stores)
//  d_rdata   out  DW     load data
//  men       out  1      memory command valid (registered)
//  maddr     out  AW     memory address (registered)
//  mwe       out  DW/8   memory byte write enables (registered)
//  mwdata    out  DW     memory write data (registered)
//  mrdata    in   DW     memory read data, valid LAT cycles after command
// BEHAVIOUR
//  Reset: all outputs 0; wait counter 0; last-grant pointer = fetch (data wins first tie);
//   response tag pipeline cleared -> reads in flight at reset are dropped, no rvalid after reset.
//  Arbitration (combinational, same cycle as valid):
//   - exactly one of i_ready/d_ready may be high; neither when no valid.
//   - only one valid -> it is granted.
//   - both valid -> round-robin: grant the requester not granted last, UNLESS wait counter of the
//     other reached MAX_WAIT, in which case that one is granted (guard overrides round-robin).
//   - wait counter (per requester, saturating at MAX_WAIT): +1 each cycle it is valid and not
//     granted; cleared on its grant or when it drops valid.
//  Command: on edge where X_valid && X_ready: men<=1, maddr<=X_addr, mwe<=d_we (0 for fetch),
//   mwdata<=d_wdata (0 for fetch). No accept -> men<=0, mwe<=0; maddr/mwdata hold.
//   Throughput: one command per cycle, back-to-back allowed, no bubbles.
//  Response: LAT-deep tag shift register records {read, is_data} per issued command.
//   When tag exits: read&fetch -> i_rvalid=1, i_rdata=mrdata; read&data -> d_rvalid=1,
//   d_rdata=mrdata. rdata outputs 0 when rvalid is 0. Stores (mwe!=0) produce no response.
//   Responses return in issue order; at most one rvalid per cycle.
//  Latency: accept at edge E -> men high during cycle after E -> rvalid high during cycle
//   after edge E+1+LAT... precisely: rvalid asserted LAT cycles after men.
//  Requester protocol: X_addr/d_we/d_wdata must be stable while X_valid && !X_ready;
//   a requester may deassert valid without being granted (request withdrawn, counter cleared).
//  Simultaneous reset with request: reset wins; no command issued, ready outputs forced 0.
//  Width rule: DW must be a multiple of 8; addresses passed unmodified (no alignment check).
// TESTING
//  1 Only i_valid, addr 0x0,0x4,0x8 back-to-back -> i_ready each cycle, men 3 cycles, i_rvalid
//    3 consecutive cycles LAT after each, i_rdata = mem[0],mem[4],mem[8].
//  2 Both valid continuously, MAX_WAIT=4 -> grants alternate D,I,D,I..., first grant data.
//  3 Store d_we=4'hF addr 0x100 data 0xDEADBEEF then load 0x100 -> mwe=F once, no d_rvalid
//    for store, load d_rdata=0xDEADBEEF.
//  4 Mixed fetch/load stream, LAT=3 -> every rvalid routed to correct port in issue order.
//  5 Reset asserted 1 cycle after a read is issued -> no rvalid ever for it; all outputs 0.
//  6 Withdrawn request: d_valid high 2 cycles while fetch wins, then low -> wait counter 0, no d command.

Source files
------------

// File: rtl/imem_dmem_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store traffic,
// registering the memory command and routing read data back to whoever issued it.
module imem_dmem_arbiter #(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int LAT      = 1,
   parameter int MAX_WAIT = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_valid,
   input  logic [AW-1:0]   i_addr,
   output logic            i_ready,
   output logic            i_rvalid,
   output logic [DW-1:0]   i_rdata,
   input  logic            d_valid,
   input  logic [AW-1:0]   d_addr,
   input  logic [DW/8-1:0] d_we,
   input  logic [DW-1:0]   d_wdata,
   output logic            d_ready,
   output logic            d_rvalid,
   output logic [DW-1:0]   d_rdata,
   output logic            men,
   output logic [AW-1:0]   maddr,
   output logic [DW/8-1:0] mwe,
   output logic [DW-1:0]   mwdata,
   input  logic [DW-1:0]   mrdata
);

   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

   typedef enum logic {GRANT_FETCH = 1'b0, GRANT_DATA = 1'b1} grant_t;

   grant_t        last_grant;
   logic [WW-1:0] i_wait;
   logic [WW-1:0] d_wait;
   logic          grant_i;
   logic          grant_d;
   logic          cmd_is_data;
   logic [LAT-1:0] tag_rd;
   logic [LAT-1:0] tag_data;

   // A starved requester beats round-robin; reset suppresses every grant
   always_comb begin
      grant_i = 1'b0;
      grant_d = 1'b0;
      if (!reset) begin
         if (i_valid && d_valid) begin
            if (i_wait == WAIT_MAX)
               grant_i = 1'b1;
            else if (d_wait == WAIT_MAX)
               grant_d = 1'b1;
            else if (last_grant == GRANT_FETCH)
               grant_d = 1'b1;
            else
               grant_i = 1'b1;
         end else if (i_valid) begin
            grant_i = 1'b1;
         end else if (d_valid) begin
            grant_d = 1'b1;
         end
      end
   end

   assign i_ready = grant_i;
   assign d_ready = grant_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant <= GRANT_FETCH;
         i_wait     <= '0;
         d_wait     <= '0;
      end else begin
         if (grant_i)
            last_grant <= GRANT_FETCH;
         else if (grant_d)
            last_grant <= GRANT_DATA;

         if (!i_valid || grant_i)
            i_wait <= '0;
         else if (i_wait != WAIT_MAX)
            i_wait <= i_wait + 1'b1;

         if (!d_valid || grant_d)
            d_wait <= '0;
         else if (d_wait != WAIT_MAX)
            d_wait <= d_wait + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         men         <= 1'b0;
         maddr       <= '0;
         mwe         <= '0;
         mwdata      <= '0;
         cmd_is_data <= 1'b0;
      end else if (grant_d) begin
         men         <= 1'b1;
         maddr       <= d_addr;
         mwe         <= d_we;
         mwdata      <= d_wdata;
         cmd_is_data <= 1'b1;
      end else if (grant_i) begin
         men         <= 1'b1;
         maddr       <= i_addr;
         mwe         <= '0;
         mwdata      <= '0;
         cmd_is_data <= 1'b0;
      end else begin
         men <= 1'b0;
         mwe <= '0;
      end
   end

   // Tags enter as the command reaches memory and exit exactly when its read data does
   always_ff @(posedge clk) begin
      if (reset) begin
         tag_rd   <= '0;
         tag_data <= '0;
      end else begin
         tag_rd[0]   <= men && (mwe == '0);
         tag_data[0] <= cmd_is_data;
         for (int k = 1; k < LAT; k++) begin
            tag_rd[k]   <= tag_rd[k-1];
            tag_data[k] <= tag_data[k-1];
         end
      end
   end

   always_comb begin
      i_rvalid = !reset && tag_rd[LAT-1] && !tag_data[LAT-1];
      d_rvalid = !reset && tag_rd[LAT-1] && tag_data[LAT-1];
      i_rdata  = i_rvalid ? mrdata : '0;
      d_rdata  = d_rvalid ? mrdata : '0;
   end

endmodule
